// File: rtl/ysyx_23060025_ifu_ctrl_pkg.sv
// Shared IFU definitions: state encodings (also decoded by the PC counter),
// fetch error cause codes and the AXI response code for OKAY.
package ysyx_23060025_ifu_ctrl_pkg;

  typedef enum logic [1:0] {
    IFU_SEND_ADDR   = 2'b00,
    IFU_WAIT_DATA   = 2'b01,
    IFU_WAIT_FINISH = 2'b10,
    IFU_BOOT        = 2'b11
  } ifu_state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_ACCESS    = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060025_ifu_ctrl.sv
// IFU fetch sequencer: one AXI4-Lite instruction read at a time, hands the
// result to the IDU and waits for the WBU retire pulse before the next fetch.
module ysyx_23060025_ifu_ctrl
  import ysyx_23060025_ifu_ctrl_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int CNT_LEN  = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] pc_i,
  output logic                arvalid_o,
  output logic [ADDR_LEN-1:0] araddr_o,
  input  logic                arready_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          rresp_i,
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] inst_pc_o,
  output logic                inst_valid_o,
  input  logic                inst_ready_i,
  input  logic                last_finish_i,
  output logic [1:0]          con_state_o,
  output logic                pc_update_o,
  output logic                fetch_err_o,
  output logic [1:0]          err_cause_o,
  output logic [CNT_LEN-1:0]  fetch_cnt_o
);

  ifu_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] inst_q, inst_d;
  logic [ADDR_LEN-1:0] inst_pc_q, inst_pc_d;
  logic                inst_valid_q, inst_valid_d;
  logic                fetch_err_q, fetch_err_d;
  logic [1:0]          err_cause_q, err_cause_d;
  logic                accepted_q, accepted_d;
  logic [CNT_LEN-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic misaligned;
  logic inst_hs;

  // All handshakes (AR, R, IDU) transfer on a rising edge where valid and
  // ready are both high; a valid, once raised, holds its payload until then.
  assign misaligned  = is_misaligned(pc_i[1:0]);
  assign inst_hs     = inst_valid_q & inst_ready_i;
  assign arvalid_o   = (state_q == IFU_SEND_ADDR) & ~misaligned;
  assign araddr_o    = pc_i;
  assign rready_o    = (state_q == IFU_WAIT_DATA);
  // Retire only counts once the IDU has taken (or is taking) the instruction.
  assign pc_update_o = (state_q == IFU_WAIT_FINISH) & last_finish_i
                     & (accepted_q | inst_ready_i);

  assign con_state_o  = state_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign fetch_err_o  = fetch_err_q;
  assign err_cause_o  = err_cause_q;
  assign fetch_cnt_o  = fetch_cnt_q;

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;
    err_cause_d  = err_cause_q;
    accepted_d   = accepted_q;
    fetch_cnt_d  = fetch_cnt_q;
    unique case (state_q)
      IFU_BOOT: state_d = IFU_SEND_ADDR;
      IFU_SEND_ADDR: begin
        if (misaligned) begin
          inst_d       = '0;
          inst_pc_d    = pc_i;
          fetch_err_d  = 1'b1;
          err_cause_d  = ERR_MISALIGN;
          inst_valid_d = 1'b1;
          state_d      = IFU_WAIT_FINISH;
        end else if (arready_i) begin
          state_d = IFU_WAIT_DATA;
        end
      end
      IFU_WAIT_DATA: begin
        if (rvalid_i) begin
          inst_d       = rdata_i;
          inst_pc_d    = pc_i;
          fetch_err_d  = (rresp_i != AXI_RESP_OKAY);
          err_cause_d  = (rresp_i != AXI_RESP_OKAY) ? ERR_ACCESS : ERR_NONE;
          inst_valid_d = 1'b1;
          state_d      = IFU_WAIT_FINISH;
        end
      end
      IFU_WAIT_FINISH: begin
        if (inst_hs) begin
          inst_valid_d = 1'b0;
          accepted_d   = 1'b1;
        end
        if (pc_update_o) begin
          state_d     = IFU_SEND_ADDR;
          accepted_d  = 1'b0;
          fetch_cnt_d = fetch_cnt_q + CNT_LEN'(1);
          fetch_err_d = 1'b0;
          err_cause_d = ERR_NONE;
        end
      end
      default: state_d = IFU_BOOT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IFU_BOOT;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      err_cause_q  <= ERR_NONE;
      accepted_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      err_cause_q  <= err_cause_d;
      accepted_q   <= accepted_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_ifu_ctrl.sv
// Directed bench for the IFU fetch sequencer; AR addresses and IDU
// transfers are checked by a monitor against expected queues.
module tb_ysyx_23060025_ifu_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] pc_i;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic        arready_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        last_finish_i;
  logic [1:0]  con_state_o;
  logic        pc_update_o;
  logic        fetch_err_o;
  logic [1:0]  err_cause_o;
  logic [31:0] fetch_cnt_o;

  // expected IDU transfer: {inst, pc, err, cause}
  logic [66:0] exp_q[$];
  logic [31:0] ar_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_23060025_ifu_ctrl dut (
    .clock(clock), .reset(reset), .pc_i(pc_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .last_finish_i(last_finish_i),
    .con_state_o(con_state_o), .pc_update_o(pc_update_o),
    .fetch_err_o(fetch_err_o), .err_cause_o(err_cause_o), .fetch_cnt_o(fetch_cnt_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (arvalid_o && arready_i) begin
        if (ar_q.size() == 0) chk("ar_unexpected", {35'd0, araddr_o}, 67'h7_ffff_ffff);
        else chk("ar_addr", {35'd0, araddr_o}, {35'd0, ar_q.pop_front()});
      end
      if (inst_valid_o && inst_ready_i) begin
        if (exp_q.size() == 0) chk("idu_unexpected", {inst_o, inst_pc_o, fetch_err_o, err_cause_o}, '1);
        else chk("idu_xfer", {inst_o, inst_pc_o, fetch_err_o, err_cause_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; pc_i = 32'h8000_0000; arready_i = 1'b1; rvalid_i = 1'b0;
    rdata_i = '0; rresp_i = 2'b00; inst_ready_i = 1'b0; last_finish_i = 1'b0;
    tick(); tick();
    chk("rst_state", 67'(con_state_o), 67'd3);
    chk("rst_outs", 67'({arvalid_o, rready_o, pc_update_o, inst_valid_o, fetch_err_o, err_cause_o}), 67'd0);
    chk("rst_regs", 67'({inst_o, fetch_cnt_o}), 67'd0);

    // fetch 1: zero wait states, OKAY
    reset = 1'b0;
    #1 chk("boot_state", 67'(con_state_o), 67'd3);
    ar_q.push_back(32'h8000_0000);
    tick();
    chk("send_state", 67'(con_state_o), 67'd0);
    chk("send_ar", 67'({arvalid_o, araddr_o}), {34'd0, 1'b1, 32'h8000_0000});
    tick();
    chk("wait_data", 67'({con_state_o, rready_o, arvalid_o}), 67'b0110);
    arready_i = 1'b0;
    rvalid_i = 1'b1; rdata_i = 32'h0000_0413; rresp_i = 2'b00; inst_ready_i = 1'b1;
    exp_q.push_back({32'h0000_0413, 32'h8000_0000, 1'b0, 2'b00});
    tick();
    rvalid_i = 1'b0;
    chk("f1_valid", 67'({con_state_o, inst_valid_o, inst_o}), {32'd0, 2'b10, 1'b1, 32'h0000_0413});
    tick();
    chk("f1_accepted", 67'(inst_valid_o), 67'd0);
    last_finish_i = 1'b1; pc_i = 32'h8000_0004;
    #1 chk("f1_pc_update", 67'({pc_update_o, fetch_cnt_o}), {34'd0, 1'b1, 32'd0});
    tick();
    last_finish_i = 1'b0;
    #1 chk("f1_done", 67'({con_state_o, pc_update_o, fetch_cnt_o}), {32'd0, 2'b00, 1'b0, 32'd1});

    // fetch 2: five AR wait states, then SLVERR response
    for (int i = 0; i < 5; i++) begin
      chk("ar_stall", 67'({con_state_o, arvalid_o, araddr_o}), {32'd0, 2'b00, 1'b1, 32'h8000_0004});
      tick();
    end
    ar_q.push_back(32'h8000_0004);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    chk("f2_wait_data", 67'(con_state_o), 67'd1);
    rvalid_i = 1'b1; rdata_i = 32'hdead_beef; rresp_i = 2'b10; inst_ready_i = 1'b0;
    exp_q.push_back({32'hdead_beef, 32'h8000_0004, 1'b1, 2'b10});
    tick();
    rvalid_i = 1'b0; rresp_i = 2'b00;
    chk("f2_err", 67'({con_state_o, inst_valid_o, fetch_err_o, err_cause_o}), 67'b10_1_1_10);
    last_finish_i = 1'b1;
    #1 chk("f2_early_retire", 67'(pc_update_o), 67'd0);
    tick();
    last_finish_i = 1'b0;
    chk("f2_held", 67'({con_state_o, inst_valid_o, fetch_cnt_o}), {32'd0, 2'b10, 1'b1, 32'd1});
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    chk("f2_accepted", 67'({con_state_o, inst_valid_o, fetch_err_o}), 67'b10_0_1);
    last_finish_i = 1'b1; pc_i = 32'h8000_0002;
    #1 chk("f2_pc_update", 67'(pc_update_o), 67'd1);
    tick();
    last_finish_i = 1'b0;
    chk("f2_cleared", 67'({con_state_o, fetch_err_o, err_cause_o, fetch_cnt_o}), {32'd0, 2'b00, 1'b0, 2'b00, 32'd2});

    // fetch 3: misaligned PC, no AR issued
    chk("mis_no_ar", 67'(arvalid_o), 67'd0);
    exp_q.push_back({32'h0, 32'h8000_0002, 1'b1, 2'b01});
    tick();
    chk("mis_err", 67'({con_state_o, inst_valid_o, fetch_err_o, err_cause_o, inst_o}),
        {32'd0, 2'b10, 1'b1, 1'b1, 2'b01, 32'd0});
    inst_ready_i = 1'b1; last_finish_i = 1'b1; pc_i = 32'h8000_0008;
    #1 chk("mis_same_cycle_update", 67'(pc_update_o), 67'd1);
    tick();
    inst_ready_i = 1'b0; last_finish_i = 1'b0;
    chk("mis_done", 67'({con_state_o, inst_valid_o, fetch_cnt_o}), {32'd0, 2'b00, 1'b0, 32'd3});

    // fetch 4: reset while waiting for data
    ar_q.push_back(32'h8000_0008);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    chk("f4_wait_data", 67'(con_state_o), 67'd1);
    reset = 1'b1;
    #1 chk("mid_rst", 67'({con_state_o, inst_valid_o, rready_o, fetch_cnt_o}), 67'b11_0_0 << 32);
    tick();
    reset = 1'b0;
    #1 chk("rerelease_boot", 67'(con_state_o), 67'd3);
    tick();
    chk("rerelease_send", 67'({con_state_o, arvalid_o}), 67'b00_1);

    chk("ar_q_empty", 67'(ar_q.size()), 67'd0);
    chk("exp_q_empty", 67'(exp_q.size()), 67'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
